// File: rtl/issue_ctrl.sv
// Decode-stage issue controller: pending-write scoreboard for 32 registers,
// RAW/WAW hold of decode, and a fixed-length flush window after taken branches.
//
//   state | meaning
//   RUN   | normal issue, stalls only on scoreboard hazards
//   FLUSH | squash window after a taken branch, decode held
module issue_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             req,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [4:0]       dec_rs1,
    input  logic             dec_rs1_used,
    input  logic [4:0]       dec_rs2,
    input  logic             dec_rs2_used,
    input  logic [4:0]       dec_rd,
    input  logic             dec_rd_write,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             branch_taken,
    output logic             stall,
    output logic             issue,
    output logic             flush_out,
    output logic [31:0]      pending,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    localparam logic [3:0] RELOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       hazard;
    logic       rs1_haz, rs2_haz, rd_haz;
    logic [31:0] pending_nxt;

    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (branch_taken) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = RELOAD;
                end
            end
            FLUSH: begin
                if (branch_taken) begin
                    cnt_nxt = RELOAD;
                end else if (cnt == 4'd0) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Index 0 is never pending, but is excluded explicitly so x0 cannot hazard.
    always_comb begin
        rs1_haz = dec_rs1_used && (dec_rs1 != 5'd0) && pending[dec_rs1];
        rs2_haz = dec_rs2_used && (dec_rs2 != 5'd0) && pending[dec_rs2];
        rd_haz  = dec_rd_write && (dec_rd  != 5'd0) && pending[dec_rd];
        hazard  = dec_valid && (rs1_haz || rs2_haz || rd_haz);
        stall   = reset && (hazard || (state == FLUSH) || branch_taken);
        issue   = reset && dec_valid && !stall;
        flush_out = (state == FLUSH);
    end

    // Set is applied after clear: the issuing instruction is younger than the writeback.
    always_comb begin
        pending_nxt = pending;
        if (wb_valid && (wb_rd != 5'd0)) begin
            pending_nxt[wb_rd] = 1'b0;
        end
        if (issue && dec_rd_write && (dec_rd != 5'd0)) begin
            pending_nxt[dec_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge req or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (stall && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Issue/hazard controller that sequences the decode stage.
- Keeps a per-register pending-write scoreboard for the 32 architectural registers.
- Holds decode via its rs_read input while a source or destination register has a write in flight.
- Inserts a fixed-length flush window after a taken branch.
- Sits between decode and execute/writeback; its stall output drives decode's rs_read directly.

Parameters:
- FLUSH_CYCLES, 2, number of cycles the flush window lasts after branch_taken (legal 1..15).
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- req  input  1  clock; all state changes on posedge req.
- reset  input  1  asynchronous, active-low reset: 0 resets immediately, 1 runs.
- dec_valid  input  1  decode holds a valid instruction.
- dec_rs1  input  5  source 1 index.
- dec_rs1_used  input  1  instruction reads rs1.
- dec_rs2  input  5  source 2 index.
- dec_rs2_used  input  1  instruction reads rs2 (R, S, B types only).
- dec_rd  input  5  destination index.
- dec_rd_write  input  1  instruction writes rd.
- wb_valid  input  1  writeback (or squash) of a pending destination this cycle.
- wb_rd  input  5  register index being written back or squashed.
- branch_taken  input  1  execute resolved a taken branch this cycle.
- stall  output  1  to decode rs_read: 1 holds decode registers.
- issue  output  1  instruction accepted into execute this cycle.
- flush_out  output  1  squash the instruction currently in decode/execute.
- pending  output  32  scoreboard vector; bit 0 is always 0.
- stall_cycles  output  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - pending=0, state=RUN, flush counter=0, flush_out=0, stall_cycles=0.
  - While reset=0, stall and issue are 0. Reset mid-flush abandons the flush.
- FSM states: RUN, FLUSH.
  - RUN -> FLUSH on branch_taken=1; counter loads FLUSH_CYCLES-1.
  - In FLUSH, counter decrements each cycle. FLUSH -> RUN when counter=0 and branch_taken=0.
  - branch_taken=1 while in FLUSH reloads the counter to FLUSH_CYCLES-1 and stays in FLUSH.
  - flush_out is a registered output, 1 exactly while state=FLUSH, so it is 1 for FLUSH_CYCLES cycles per isolated branch.
- Hazard (combinational), hazard = dec_valid AND (any of):
  - dec_rs1_used AND pending[dec_rs1].
  - dec_rs2_used AND pending[dec_rs2].
  - dec_rd_write AND pending[dec_rd] (WAW).
  - A register index of 0 never hazards.
- stall = hazard OR state==FLUSH OR branch_taken. Combinational, same cycle.
- issue = dec_valid AND NOT stall. The branch_taken cycle never issues.
- Scoreboard update on posedge req:
  - set bit dec_rd when issue AND dec_rd_write AND dec_rd!=0.
  - clear bit wb_rd when wb_valid AND wb_rd!=0.
  - Same register set and cleared in the same cycle: set wins, because the issuing instruction is younger.
- Bypass: a clear and a hazard check on the same register in the same cycle still stalls that cycle. There is no same-cycle forwarding; issue occurs the following cycle.
- Execute must assert wb_valid for every issued rd-writing instruction, including ones squashed by flush. Otherwise pending never clears.
- stall_cycles increments on each cycle with stall=1 and reset=1. It holds at all-ones (no wrap).
- wb_valid for a register whose pending bit is already 0: no effect, no error.

Test Plan:
- Reset release: reset=0 then 1 -> pending=0, stall=0, flush_out=0, stall_cycles=0; dec_valid=1 with no hazards gives issue=1 in the same cycle.
- RAW stall: issue rd=5 write. Next cycle dec_rs1=5 used -> stall=1, issue=0. wb_valid, wb_rd=5 -> pending[5]=0 after the edge; issue=1 the following cycle; stall_cycles increased by 2.
- x0 handling: issue dec_rd=0 write, then dec_rs1=0 used -> pending stays 0, no stall.
- Set/clear collision: pending[7]=1; in the same cycle wb_rd=7 and an issued instruction with rd=7 -> pending[7] remains 1.
- Flush: branch_taken pulse with FLUSH_CYCLES=2 -> stall=1 in the branch cycle; flush_out=1 for exactly 2 cycles; issue resumes in cycle 3. A second branch_taken during flush extends the window by 2 from that point.
- Async reset mid-flush with pending[3]=1 -> immediate pending=0, flush_out=0, state RUN, without waiting for a req edge.
